// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: qualifies a signed loop-error stream against lock/unlock thresholds.
// Optional macro LOCK_MON_PEAK_HOLD_EN adds a peak |error| register; without it peak_err_o is tied to 0.
module pll_lock_monitor #(
    parameter int ERR_WIDTH     = 8,
    parameter int LOCK_THRESH   = 4,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 8,
    parameter int UNLOCK_COUNT  = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic                        fpga_clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        ref_clk_i,
    input  logic signed [ERR_WIDTH-1:0] error_i,
    output logic                        locked_o,
    output logic [1:0]                  state_o,
    output logic                        lock_lost_o,
    output logic [ERR_WIDTH-1:0]        peak_err_o,
    output logic                        timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        SLIP    = 2'd3
    } state_e;

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [GOOD_W-1:0]    GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]     BAD_LAST   = BAD_W'(UNLOCK_COUNT - 1);
    localparam logic [TMO_W-1:0]     TMO_MAX    = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [ERR_WIDTH-1:0] LOCK_THR   = ERR_WIDTH'(LOCK_THRESH);
    localparam logic [ERR_WIDTH-1:0] UNLOCK_THR = ERR_WIDTH'(UNLOCK_THRESH);
    localparam logic [ERR_WIDTH-1:0] MOST_NEG   = {1'b1, {(ERR_WIDTH-1){1'b0}}};
    localparam logic [ERR_WIDTH-1:0] MAG_MAX    = {1'b0, {(ERR_WIDTH-1){1'b1}}};

    state_e              state_q, state_d;
    logic [2:0]          ref_sync_q, ref_sync_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                timeout_q, timeout_d;
    logic                lost_q, lost_d;
    logic                strobe;
    logic [ERR_WIDTH-1:0] err_mag;

    // Bits [1:0] are the synchroniser; bit 2 is the previous value for edge detection.
    always_comb begin
        ref_sync_d = {ref_sync_q[1:0], ref_clk_i};
        strobe     = ref_sync_q[1] & ~ref_sync_q[2];
    end

    // The most negative code has no positive twin, so it saturates to the largest magnitude.
    always_comb begin
        if ($unsigned(error_i) == MOST_NEG) begin
            err_mag = MAG_MAX;
        end else if (error_i[ERR_WIDTH-1]) begin
            err_mag = $unsigned(-error_i);
        end else begin
            err_mag = $unsigned(error_i);
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        lost_d    = 1'b0;

        if (!enable_i) begin
            state_d   = IDLE;
            good_d    = '0;
            bad_d     = '0;
            tmo_d     = '0;
            timeout_d = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ACQUIRE;
        end else if (strobe) begin
            tmo_d = '0;
            case (state_q)
                ACQUIRE: begin
                    if (err_mag <= LOCK_THR) begin
                        if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (err_mag > UNLOCK_THR) begin
                        state_d = SLIP;
                        bad_d   = BAD_W'(1);
                    end
                end
                SLIP: begin
                    if (err_mag <= UNLOCK_THR) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end else if (bad_q == BAD_LAST) begin
                        state_d = ACQUIRE;
                        bad_d   = '0;
                        lost_d  = 1'b1;
                    end else begin
                        bad_d = bad_q + BAD_W'(1);
                    end
                end
                default: ;
            endcase
        end else if (tmo_q == TMO_LAST) begin
            // Counter parks at TIMEOUT so a dead reference forces ACQUIRE only once.
            tmo_d     = TMO_MAX;
            timeout_d = 1'b1;
            state_d   = ACQUIRE;
            good_d    = '0;
            bad_d     = '0;
            lost_d    = (state_q == LOCKED) || (state_q == SLIP);
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ref_sync_q <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_sync_q <= ref_sync_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
            lost_q     <= lost_d;
        end
    end

`ifdef LOCK_MON_PEAK_HOLD_EN
    logic [ERR_WIDTH-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (enable_i && strobe && ((state_q == LOCKED) || (state_q == SLIP)) && (err_mag > peak_q)) begin
            peak_d = err_mag;
        end
        if ((state_q == ACQUIRE) && (state_d == LOCKED)) begin
            peak_d = '0;
        end
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_err_o = peak_q;
`else
    assign peak_err_o = '0;
`endif

    assign state_o     = state_q;
    assign locked_o    = (state_q == LOCKED) || (state_q == SLIP);
    assign lock_lost_o = lost_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: a rule-level model queues expected state
// transitions at stimulus time; a negedge monitor pops and compares them as the DUT changes state.
module tb_pll_lock_monitor;

    localparam int W             = 8;
    localparam int LOCK_THRESH   = 4;
    localparam int LOCK_COUNT    = 16;
    localparam int UNLOCK_THRESH = 8;
    localparam int UNLOCK_COUNT  = 4;
    localparam int TIMEOUT       = 1024;

    logic                fpga_clk_i = 1'b0;
    logic                reset_i    = 1'b1;
    logic                enable_i   = 1'b0;
    logic                ref_clk_i  = 1'b0;
    logic signed [W-1:0] error_i    = '0;
    logic                locked_o;
    logic [1:0]          state_o;
    logic                lock_lost_o;
    logic [W-1:0]        peak_err_o;
    logic                timeout_o;

    always #5 fpga_clk_i = ~fpga_clk_i;

    pll_lock_monitor #(
        .ERR_WIDTH    (W),
        .LOCK_THRESH  (LOCK_THRESH),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_THRESH(UNLOCK_THRESH),
        .UNLOCK_COUNT (UNLOCK_COUNT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .ref_clk_i  (ref_clk_i),
        .error_i    (error_i),
        .locked_o   (locked_o),
        .state_o    (state_o),
        .lock_lost_o(lock_lost_o),
        .peak_err_o (peak_err_o),
        .timeout_o  (timeout_o)
    );

    typedef struct {
        int st;
        int lost;
        int tmo;
        int peak;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    // Reference model: 0 idle, 1 acquiring, 2 locked, 3 slipping.
    int m_state = 0;
    int m_good  = 0;
    int m_bad   = 0;
    int m_tmo   = 0;
    int m_peak  = 0;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int exp_peak();
`ifdef LOCK_MON_PEAK_HOLD_EN
        return m_peak;
`else
        return 0;
`endif
    endfunction

    function automatic int mag_of(input int e);
        if (e == -(1 << (W - 1))) return (1 << (W - 1)) - 1;
        return (e < 0) ? -e : e;
    endfunction

    task automatic push_ev(input int lost);
        ev_t e;
        e.st   = m_state;
        e.lost = lost;
        e.tmo  = m_tmo;
        e.peak = exp_peak();
        exp_q.push_back(e);
    endtask

    task automatic model_strobe(input int e);
        int mag;
        int old;
        int lost;
        mag  = mag_of(e);
        old  = m_state;
        lost = 0;
        if (m_state == 1) begin
            if (mag <= LOCK_THRESH) begin
                m_good++;
                if (m_good == LOCK_COUNT) begin
                    m_state = 2;
                    m_good  = 0;
                    m_peak  = 0;
                end
            end else begin
                m_good = 0;
            end
        end else if (m_state >= 2) begin
            if (mag > m_peak) m_peak = mag;
            if (mag <= UNLOCK_THRESH) begin
                m_state = 2;
                m_bad   = 0;
            end else begin
                m_bad   = (m_state == 2) ? 1 : m_bad + 1;
                m_state = 3;
                if (m_bad == UNLOCK_COUNT) begin
                    m_state = 1;
                    m_bad   = 0;
                    m_good  = 0;
                    lost    = 1;
                end
            end
        end
        if (m_state != old) push_ev(lost);
    endtask

    task automatic drain_check();
        check("event_drain", exp_q.size(), 0);
        exp_q.delete();
        check("state_now", int'(state_o), m_state);
        check("locked_now", int'(locked_o), int'(m_state >= 2));
    endtask

    // One reference period carrying error value e; ref edges are deliberately off the clock grid.
    task automatic slot(input int e);
        int hold;
        int low;
        hold = $urandom_range(3, 5);
        low  = $urandom_range(4, 7);
        model_strobe(e);
        @(posedge fpga_clk_i);
        #2 error_i = e[W-1:0];
        #1 ref_clk_i = 1'b1;
        repeat (hold) @(posedge fpga_clk_i);
        #3 ref_clk_i = 1'b0;
        repeat (low) @(posedge fpga_clk_i);
        #2;
        drain_check();
    endtask

    task automatic set_enable(input logic v);
        @(negedge fpga_clk_i);
        if (!v) begin
            m_tmo  = 0;
            m_good = 0;
            m_bad  = 0;
            if (m_state != 0) begin
                m_state = 0;
                push_ev(0);
            end
        end else begin
            m_state = 1;
            push_ev(0);
        end
        enable_i = v;
        repeat (4) @(posedge fpga_clk_i);
        #2;
        drain_check();
    endtask

    task automatic pause_ref(input int cycles);
        int old;
        old = m_state;
        if (old != 0) begin
            m_tmo   = 1;
            m_good  = 0;
            m_bad   = 0;
            m_state = 1;
            if (old != 1) push_ev(int'(old >= 2));
        end
        repeat (cycles) @(posedge fpga_clk_i);
        #2;
        drain_check();
        check("timeout_flag", int'(timeout_o), m_tmo);
    endtask

    function automatic int rand_err();
        int r;
        int v;
        r = int'($urandom_range(0, 99));
        if (m_state == 1) begin
            if (r < 94) return int'($urandom_range(0, 8)) - 4;
            v = int'($urandom_range(5, 127));
            return (r < 97) ? v : -v;
        end
        if (r < 60) return int'($urandom_range(0, 16)) - 8;
        if (r < 95) begin
            v = int'($urandom_range(9, 127));
            return (r < 78) ? v : -v;
        end
        return -128;
    endfunction

    // Monitor: every state change must match the head of the expected-transition queue.
    initial begin
        int   prev;
        int   cur;
        ev_t  e;
        prev = 0;
        forever begin
            @(negedge fpga_clk_i);
            cur = int'(state_o);
            if (cur != prev) begin
                check("event_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ev_state", cur, e.st);
                    check("ev_lock_lost", int'(lock_lost_o), e.lost);
                    check("ev_timeout", int'(timeout_o), e.tmo);
                    check("ev_peak", int'(peak_err_o), e.peak);
                end
            end
            if (lock_lost_o) check("lost_only_on_transition", int'(cur != prev), 1);
            prev = cur;
        end
    end

    initial begin
        int pauses;
        pauses = 0;

        #23;
        check("rst_state", int'(state_o), 0);
        check("rst_locked", int'(locked_o), 0);
        check("rst_lost", int'(lock_lost_o), 0);
        check("rst_timeout", int'(timeout_o), 0);
        check("rst_peak", int'(peak_err_o), 0);
        @(negedge fpga_clk_i);
        reset_i = 1'b0;
        set_enable(1'b1);

        // Acquire with a steady +3 error.
        for (int i = 0; i < 16; i++) slot(3);

        // Three bad samples then a good one: slip and recover without losing lock.
        for (int i = 0; i < 3; i++) slot(9);
        slot(0);

        // Four saturating negative samples drop lock.
        for (int i = 0; i < 4; i++) slot(-128);
        check("peak_after_loss", int'(peak_err_o), exp_peak());

        // Fifteen good, one just over threshold, then sixteen more needed.
        for (int i = 0; i < 15; i++) slot(int'($urandom_range(0, 8)) - 4);
        slot(5);
        for (int i = 0; i < 16; i++) slot(-4);

        // Reference dies while locked, then returns and relocks.
        pause_ref(1100);
        for (int i = 0; i < 16; i++) slot(1);
        check("timeout_sticky", int'(timeout_o), 1);

        // Unlock-threshold boundaries.
        slot(8);
        slot(-8);
        slot(9);
        slot(-8);

        // Disabling while locked returns to idle silently and clears the timeout flag.
        set_enable(1'b0);
        check("timeout_cleared_idle", int'(timeout_o), 0);
        set_enable(1'b1);

        for (int n = 0; n < 250; n++) begin
            slot(rand_err());
            if ($urandom_range(0, 99) < 2) begin
                set_enable(1'b0);
                set_enable(1'b1);
            end else if (pauses < 3 && $urandom_range(0, 99) < 1) begin
                pause_ref(1100);
                pauses++;
            end
        end

        // Relock, then hit reset off the clock grid.
        set_enable(1'b0);
        set_enable(1'b1);
        for (int i = 0; i < 16; i++) slot(int'($urandom_range(0, 8)) - 4);
        @(posedge fpga_clk_i);
        #4;
        m_state = 0;
        m_good  = 0;
        m_bad   = 0;
        m_tmo   = 0;
        m_peak  = 0;
        push_ev(0);
        reset_i = 1'b1;
        #1;
        check("async_rst_state", int'(state_o), 0);
        check("async_rst_locked", int'(locked_o), 0);
        check("async_rst_lost", int'(lock_lost_o), 0);
        check("async_rst_timeout", int'(timeout_o), 0);
        check("async_rst_peak", int'(peak_err_o), 0);
        repeat (3) @(negedge fpga_clk_i);
        m_state = 1;
        push_ev(0);
        reset_i = 1'b0;
        repeat (4) @(posedge fpga_clk_i);
        #2;
        drain_check();

        for (int i = 0; i < 20; i++) slot(rand_err());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
